// File: rtl/token_load_if.sv
// Handshake and write-port bundle between the config source, the loader and the decompressor.
// No logic: signal grouping only, zero latency.
// Backpressure: in_ready from the loader gates the in_valid/in_data word stream.
interface token_load_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 7
);
  // load request from the boot/config side
  logic              start;
  logic [ADDR_W-1:0] count;
  // token word stream
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  // token-table write port and status
  logic              wme;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  WriteData;
  logic              cpu_stall;
  logic              busy;
  logic              done;
  logic              err;

  // boot/config source side
  modport master (
    output start, count, in_valid, in_data,
    input  in_ready, wme, waddr, WriteData, cpu_stall, busy, done, err
  );

  // loader side
  modport slave (
    input  start, count, in_valid, in_data,
    output in_ready, wme, waddr, WriteData, cpu_stall, busy, done, err
  );
endinterface

// File: rtl/token_load_ctrl.sv
// Loads the decompressor token table from a valid/ready word stream and stalls CPU fetch until it is complete.
// Latency: each accepted word is written one cycle after its handshake; done coincides with the last write.
// Backpressure: in_ready is high only while loading; in_valid gaps simply pause the load, no bubbles are written.
module token_load_ctrl #(
  parameter int WIDTH       = 32,
  parameter int TOKEN_DEPTH = 102,
  parameter int ADDR_W      = 7
) (
  input logic          clk,
  input logic          reset,
  token_load_if.slave  bus
);

  // Largest legal request expressed at count width (2**ADDR_W > TOKEN_DEPTH keeps it exact).
  localparam logic [ADDR_W-1:0] MAX_COUNT = ADDR_W'(TOKEN_DEPTH);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] remaining;

  // Registered copies of every output so the write port and stall are glitch-free.
  logic              in_ready_q;
  logic              wme_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [WIDTH-1:0]  wdata_q;
  logic              cpu_stall_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              hs;

  // A word moves only while the loader advertises ready.
  assign hs = bus.in_valid & in_ready_q;

  // Controller FSM: state, write counters and all registered outputs in one place.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // Any reset abandons a load; table contents are unknown so fetch stays stalled.
      state       <= EMPTY;
      idx         <= '0;
      remaining   <= '0;
      in_ready_q  <= 1'b0;
      wme_q       <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_stall_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Write strobe and done are single-cycle unless re-armed below.
      wme_q  <= 1'b0;
      done_q <= 1'b0;

      case (state)
        LOAD: begin
          // start is deliberately ignored here; only the word stream matters.
          if (hs) begin
            wme_q     <= 1'b1;
            waddr_q   <= idx;
            wdata_q   <= bus.in_data;
            idx       <= idx + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (remaining == ADDR_W'(1)) begin
              // Final word: the first RUN cycle carries the last write and done,
              // and the stall is kept until that write is committed.
              state       <= RUN;
              in_ready_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              cpu_stall_q <= 1'b1;
            end
          end
        end

        default: begin
          // EMPTY, RUN and ERR all accept a new load request.
          if (bus.start) begin
            if (bus.count == '0) begin
              // Empty table is trivially complete: release fetch immediately.
              state       <= RUN;
              in_ready_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              err_q       <= 1'b0;
              cpu_stall_q <= 1'b0;
            end else if (bus.count > MAX_COUNT) begin
              // Request would overrun the table; park in ERR with fetch held.
              state       <= ERR;
              in_ready_q  <= 1'b0;
              busy_q      <= 1'b0;
              err_q       <= 1'b1;
              cpu_stall_q <= 1'b1;
            end else begin
              state       <= LOAD;
              idx         <= '0;
              remaining   <= bus.count;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b1;
              err_q       <= 1'b0;
              cpu_stall_q <= 1'b1;
            end
          end else if (state == RUN) begin
            // No write pending in steady RUN, so fetch is free.
            cpu_stall_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.wme       = wme_q;
  assign bus.waddr     = waddr_q;
  assign bus.WriteData = wdata_q;
  assign bus.cpu_stall = cpu_stall_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_token_load_ctrl.sv
// Self-checking bench for token_load_ctrl: vector table, directed corner sequences, random traffic vs model.
// Outputs are sampled 1ns after each rising edge; inputs change at that point too.
// Terminates after a fixed number of cycles.
module tb_token_load_ctrl;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 102;
  localparam int ADDR_W = 7;

  logic clk;
  logic reset;

  token_load_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  token_load_ctrl #(.WIDTH(WIDTH), .TOKEN_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // DUT observations, counted per sequence
  int n_wr = 0;
  int n_done = 0;
  int last_addr = -1;

  // Reference model: phase of the load and the expected outputs after an edge
  localparam int PH_EMPTY = 0, PH_LOAD = 1, PH_RUN = 2, PH_ERR = 3;
  int          m_ph = PH_EMPTY;
  int          m_idx = 0;
  int          m_left = 0;
  bit          e_wme = 0;
  int          e_addr = 0;
  logic [31:0] e_dat = '0;
  bit          e_done = 0;

  typedef struct {
    logic        rst;
    logic        st;
    logic [6:0]  cnt;
    logic        vld;
    logic [31:0] dat;
    logic        e_wme;
    logic [6:0]  e_addr;
    logic [31:0] e_dat;
    logic        e_stall;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[12];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic drive(input logic r, input logic s, input int c, input logic v, input logic [31:0] d);
    reset        = r;
    bus.start    = s;
    bus.count    = 7'(c);
    bus.in_valid = v;
    bus.in_data  = d;
  endtask

  // Model advance, from the rules: handshake writes next cycle, loads end after `count` words.
  task automatic model_step();
    e_wme  = 0;
    e_done = 0;
    if (!reset) begin
      m_ph = PH_EMPTY;
    end else if (m_ph == PH_LOAD) begin
      if (bus.in_valid) begin
        e_wme  = 1;
        e_addr = m_idx;
        e_dat  = bus.in_data;
        m_idx++;
        m_left--;
        if (m_left == 0) begin
          m_ph   = PH_RUN;
          e_done = 1;
        end
      end
    end else if (bus.start) begin
      if (int'(bus.count) == 0) begin
        m_ph   = PH_RUN;
        e_done = 1;
      end else if (int'(bus.count) > DEPTH) begin
        m_ph = PH_ERR;
      end else begin
        m_ph   = PH_LOAD;
        m_idx  = 0;
        m_left = int'(bus.count);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (bus.wme) begin
      n_wr++;
      last_addr = int'(bus.waddr);
    end
    if (bus.done) n_done++;
  endtask

  task automatic chk_model();
    chk("model_wme",   32'(bus.wme),       32'(e_wme));
    chk("model_done",  32'(bus.done),      32'(e_done));
    chk("model_rdy",   32'(bus.in_ready),  32'(m_ph == PH_LOAD));
    chk("model_busy",  32'(bus.busy),      32'(m_ph == PH_LOAD));
    chk("model_err",   32'(bus.err),       32'(m_ph == PH_ERR));
    chk("model_stall", 32'(bus.cpu_stall), 32'((m_ph != PH_RUN) || e_wme));
    if (e_wme) begin
      chk("model_waddr", 32'(bus.waddr), 32'(e_addr));
      chk("model_wdata", bus.WriteData,  e_dat);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input int c, input logic v, input logic [31:0] d);
    drive(r, s, c, v, d);
    tick();
    chk_model();
  endtask

  task automatic clr_obs();
    n_wr = 0;
    n_done = 0;
    last_addr = -1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 0, 1'b0, '0);

    // rst st cnt vld dat | wme addr dat stall busy done err rdy
    vecs[0]  = '{1'b0, 1'b0, 7'd0, 1'b0, 32'h0,         1'b0, 7'd0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 7'd0, 1'b0, 32'h0,         1'b0, 7'd0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 7'd0, 1'b1, 32'h5,         1'b0, 7'd0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 7'd0, 1'b0, 32'h0,         1'b0, 7'd0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 7'd0, 1'b0, 32'h0,         1'b0, 7'd0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 7'd0, 1'b0, 32'h0,         1'b0, 7'd0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 7'd3, 1'b0, 32'h0,         1'b0, 7'd0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 7'd0, 1'b1, 32'hA000_0000, 1'b1, 7'd0, 32'hA000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 7'd0, 1'b1, 32'hA000_0001, 1'b1, 7'd1, 32'hA000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 7'd0, 1'b1, 32'hA000_0002, 1'b1, 7'd2, 32'hA000_0002, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 7'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 7'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 7'd0, 1'b0, 32'h0,         1'b0, 7'd0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset/idle and a 3-word back-to-back load, checked against hand-derived vectors
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].st, int'(vecs[i].cnt), vecs[i].vld, vecs[i].dat);
      tick();
      chk($sformatf("vec%0d_wme", i),   32'(bus.wme),       32'(vecs[i].e_wme));
      chk($sformatf("vec%0d_stall", i), 32'(bus.cpu_stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_busy", i),  32'(bus.busy),      32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_done", i),  32'(bus.done),      32'(vecs[i].e_done));
      chk($sformatf("vec%0d_err", i),   32'(bus.err),       32'(vecs[i].e_err));
      chk($sformatf("vec%0d_rdy", i),   32'(bus.in_ready),  32'(vecs[i].e_rdy));
      if (vecs[i].e_wme) begin
        chk($sformatf("vec%0d_waddr", i), 32'(bus.waddr), 32'(vecs[i].e_addr));
        chk($sformatf("vec%0d_wdata", i), bus.WriteData,  vecs[i].e_dat);
      end
      if (i == 0) begin
        chk("reset_waddr", 32'(bus.waddr), 32'd0);
        chk("reset_wdata", bus.WriteData,  32'd0);
      end
      chk_model();
    end

    // count=2 with in_valid gaps: exactly two writes at 0 and 1
    cyc(1'b1, 1'b1, 2, 1'b0, '0);
    clr_obs();
    cyc(1'b1, 1'b0, 0, 1'b1, 32'h1111_0000);
    chk("gap_first_addr", 32'(last_addr), 32'd0);
    cyc(1'b1, 1'b0, 0, 1'b0, '0);
    cyc(1'b1, 1'b0, 0, 1'b0, '0);
    cyc(1'b1, 1'b0, 0, 1'b1, 32'h1111_0001);
    cyc(1'b1, 1'b0, 0, 1'b0, '0);
    cyc(1'b1, 1'b0, 0, 1'b0, '0);
    chk("gap_writes", 32'(n_wr), 32'd2);
    chk("gap_last_addr", 32'(last_addr), 32'd1);
    chk("gap_done", 32'(n_done), 32'd1);

    // Illegal count then recovery with count=1
    clr_obs();
    cyc(1'b1, 1'b1, 103, 1'b1, 32'h2222_0000);
    cyc(1'b1, 1'b0, 0, 1'b1, 32'h2222_0001);
    cyc(1'b1, 1'b0, 0, 1'b0, '0);
    chk("err_flag", 32'(bus.err), 32'd1);
    chk("err_stall", 32'(bus.cpu_stall), 32'd1);
    chk("err_no_writes", 32'(n_wr), 32'd0);
    cyc(1'b1, 1'b1, 1, 1'b0, '0);
    chk("err_cleared", 32'(bus.err), 32'd0);
    cyc(1'b1, 1'b0, 0, 1'b1, 32'h3333_0000);
    chk("rec_wdata", bus.WriteData, 32'h3333_0000);
    cyc(1'b1, 1'b0, 0, 1'b0, '0);
    chk("rec_writes", 32'(n_wr), 32'd1);
    chk("rec_addr", 32'(last_addr), 32'd0);

    // Full-depth load with a start pulse in the middle
    cyc(1'b1, 1'b1, DEPTH, 1'b0, '0);
    clr_obs();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, (i == 50), 5, 1'b1, $urandom);
    end
    cyc(1'b1, 1'b0, 0, 1'b0, '0);
    cyc(1'b1, 1'b0, 0, 1'b0, '0);
    chk("full_writes", 32'(n_wr), 32'(DEPTH));
    chk("full_last_addr", 32'(last_addr), 32'(DEPTH - 1));
    chk("full_done_once", 32'(n_done), 32'd1);
    chk("full_stall_rel", 32'(bus.cpu_stall), 32'd0);

    // Reset mid-load, then a zero-length load
    cyc(1'b1, 1'b1, 4, 1'b0, '0);
    cyc(1'b1, 1'b0, 0, 1'b1, 32'h4444_0000);
    cyc(1'b1, 1'b0, 0, 1'b1, 32'h4444_0001);
    cyc(1'b0, 1'b0, 0, 1'b1, 32'h4444_0002);
    chk("rst_mid_stall", 32'(bus.cpu_stall), 32'd1);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_rdy", 32'(bus.in_ready), 32'd0);
    clr_obs();
    cyc(1'b1, 1'b1, 0, 1'b0, '0);
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_stall", 32'(bus.cpu_stall), 32'd0);
    cyc(1'b1, 1'b0, 0, 1'b1, 32'h5555_0000);
    chk("zero_writes", 32'(n_wr), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int sel;
      int c;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      c = 0;
      else if (sel == 1) c = int'($urandom_range(103, 127));
      else if (sel == 2) c = DEPTH;
      else               c = int'($urandom_range(1, 12));
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 24) == 0), c,
          ($urandom_range(0, 3) != 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
